i2s_tx: RTL and testbench
=========================

# i2s_tx

Serial output stage of the equalizer. Accepts the mixed 24-bit signed sample produced by the filter bank through a valid/ready handshake and buffers one sample. Generates BCLK and LRCK from the system clock and shifts each sample out MSB-first in standard I2S format. The same sample is sent in both channel slots. Sits directly downstream of the filter mixer and drives the codec DAC pins.

## Interface
- CLK_DIV, default 4: clk cycles per BCLK half-period; legal values ≥2. BCLK = clk/(2·CLK_DIV).
- clk  in  1  system clock; all logic runs on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  24  signed mixed sample from the filter bank.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  hold register is empty; a sample is accepted when valid && ready.
- bclk  out  1  I2S bit clock, registered.
- lrck  out  1  I2S word select, registered; 0 = left, 1 = right.
- sdata  out  1  I2S serial data, registered; changes only on BCLK falling edges.
- underrun  out  1  one-clk pulse when a frame starts with the hold register empty.
- underrun_cnt  out  16  saturating underrun count; present only when I2S_TX_UNDERRUN_CNT_EN is defined.

## Operation
- Divider: div_cnt counts 0..CLK_DIV-1. At the terminal count, bclk toggles and div_cnt returns to 0.
  - 0→1 is the rise edge event.
  - 1→0 is the fall edge event.
- Bit counter: bit_cnt (0..63) advances on every fall edge event and wraps 63→0.
  - lrck = (bit_cnt ≥ 32), updated at the same event.
- Frame start: the fall edge event on which bit_cnt wraps 63→0.
- Hold register: one entry plus a full flag; sample_ready = !full.
- Frame load, at frame start:
  - If full: the shift register takes the hold value and full clears.
  - If empty: the shift register takes 0 and underrun pulses.
- Simultaneous valid && ready in the frame-start cycle: the frame is still an underrun. The new sample lands in hold and is used at the next frame.
- Slot layout. Bits are numbered k = bit_cnt mod 32, and sdata is updated at each fall edge event:
  - k = 0: previous slot's trailing 0.
  - k = 1..24: sample bits 23..0.
  - k = 25..31: 0.
- The right slot (bit_cnt 32..63) repeats the left slot's sample bit-for-bit.
- No arithmetic is performed on the sample; it is a two's-complement passthrough.
- Reset values:
  - bclk = 0, div_cnt = 0, bit_cnt = 63, lrck = 1, sdata = 0.
  - full = 0, sample_ready = 1, underrun = 0, underrun_cnt = 0, shift register = 0.
- Reset mid-frame aborts the frame immediately. The buffered sample is discarded and no underrun is flagged.

## Timing
- First fall edge event is 2·CLK_DIV clk cycles after reset deasserts. It is the first frame start.
- Frame length is 64·2·CLK_DIV clk cycles.
- sample_ready drops the cycle after acceptance and rises the cycle after a frame load.
- Latency: a sample accepted before frame start N appears with its MSB on sdata at the second fall edge event of frame N.
- The accepting cycle must strictly precede the frame-start cycle.
- underrun is asserted for exactly the clk cycle following the frame-start event.
- Throughput is one sample per frame, and the source must sustain that rate.

## Configuration
- I2S_TX_UNDERRUN_CNT_EN defined:
  - underrun_cnt port and counter exist.
  - The counter increments with each underrun pulse and saturates at 16'hFFFF.
  - Only reset clears it.
- Undefined: the port and counter are absent. The underrun pulse is unaffected.

## Structure
- Shared package eq_pkg holds:
  - SAMPLE_W = 24, SLOT_W = 32, FRAME_BITS = 64.
  - typedef sample_t (logic signed [SAMPLE_W-1:0]).
- Sub-module i2s_clk_gen: divider, bclk, bit_cnt, lrck, and the rise/fall/frame-start strobes.
- i2s_tx holds the handshake, hold register, shift register and underrun logic.

## Test plan
All scenarios use CLK_DIV = 2, so a frame is 256 clk.
- Reset release, no samples:
  - bclk period is 4 clk; lrck first falls at clk 4.
  - sdata stays 0.
  - underrun pulses every 256 clk, and underrun_cnt reads 3 after three frames.
- Accept 24'h800001 before frame 0:
  - Left slot bits 1..24 = 1,0…0,1; right slot is identical.
  - Bits 25..31 are 0; sample_ready is low until the frame-start cycle+1.
- Back-to-back 24'h7FFFFF then 24'h000000, each valid at every ready:
  - Consecutive frames carry each value in both slots.
  - No underrun occurs.
- valid asserted exactly in the frame-start cycle with hold empty:
  - underrun pulses and that frame sends zeros.
  - The sample appears in the next frame.
- Reset pulse at bit_cnt 40 with hold full:
  - All outputs return to reset values the next cycle.
  - The buffered sample is never transmitted.
- With the macro, force 65536 underruns (backdoor preload to 16'hFFFE then two frames): underrun_cnt sticks at 16'hFFFF.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared equalizer sizes and sample type for the I2S output stage.
package eq_pkg;
    localparam int unsigned SAMPLE_W       = 24;
    localparam int unsigned SLOT_W         = 32;
    localparam int unsigned FRAME_BITS     = 64;
    localparam int unsigned BIT_W          = $clog2(FRAME_BITS);
    localparam int unsigned SLOT_IDX_W     = $clog2(SLOT_W);
    localparam int unsigned UNDERRUN_CNT_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Slot positions 1..SAMPLE_W carry sample bits; position 0 and the tail are zero.
    function automatic logic is_data_bit(input logic [SLOT_IDX_W-1:0] k);
        return (k >= SLOT_IDX_W'(1)) && (k <= SLOT_IDX_W'(SAMPLE_W));
    endfunction
endpackage

// File: rtl/i2s_tx_if.sv
// Sample handshake between the filter mixer (master) and the I2S transmitter (slave).
interface i2s_tx_if;
    import eq_pkg::*;

    sample_t sample_in;
    logic    sample_valid;
    logic    sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_clk_gen.sv
// BCLK/LRCK generation plus the fall-edge and frame-start strobes used by the shifter.
module i2s_clk_gen
    import eq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  bclk,
    output logic                  lrck,
    output logic                  fall_c,
    output logic                  frame_start_c,
    output logic [SLOT_IDX_W-1:0] slot_bit_c
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt_c;
    logic             tc_c;

    assign tc_c          = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_c        = tc_c && bclk;
    assign frame_start_c = fall_c && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    // FRAME_BITS is a power of two, so the increment wraps 63 -> 0 on its own.
    assign bit_nxt_c     = bit_cnt + BIT_W'(1);
    assign slot_bit_c    = bit_nxt_c[SLOT_IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= BIT_W'(FRAME_BITS - 1);
            lrck    <= 1'b1;
        end else begin
            if (tc_c) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_c) begin
                bit_cnt <= bit_nxt_c;
                lrck    <= (bit_nxt_c >= BIT_W'(SLOT_W));
            end
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry sample buffer, dual-slot MSB-first shifter, underrun flag.
// Optional saturating underrun counter enabled by I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx
    import eq_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    i2s_tx_if.slave      bus,
    output logic         bclk,
    output logic         lrck,
    output logic         sdata,
    output logic         underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
`endif
);
    logic                  fall_c;
    logic                  frame_start_c;
    logic [SLOT_IDX_W-1:0] slot_bit_c;
    logic                  accept_c;
    logic                  empty;
    sample_t               hold;
    sample_t               shreg;

    i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk           (clk),
        .reset         (reset),
        .bclk          (bclk),
        .lrck          (lrck),
        .fall_c        (fall_c),
        .frame_start_c (frame_start_c),
        .slot_bit_c    (slot_bit_c)
    );

    assign bus.sample_ready = empty;
    assign accept_c         = bus.sample_valid && empty;

    // A frame start samples the buffer state before any same-cycle acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            empty    <= 1'b1;
            hold     <= '0;
            shreg    <= '0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept_c) begin
                hold  <= bus.sample_in;
                empty <= 1'b0;
            end
            if (frame_start_c) begin
                sdata <= 1'b0;
                if (!empty) begin
                    shreg <= hold;
                    empty <= 1'b1;
                end else begin
                    shreg    <= '0;
                    underrun <= 1'b1;
                end
            end else if (fall_c) begin
                // Rotating (not shifting) restores the sample for the right slot.
                if (is_data_bit(slot_bit_c)) begin
                    sdata <= shreg[SAMPLE_W-1];
                    shreg <= {shreg[SAMPLE_W-2:0], shreg[SAMPLE_W-1]};
                end else begin
                    sdata <= 1'b0;
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (frame_start_c && empty && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx against a frame-level reference model (CLK_DIV = 2).
module tb_i2s_tx;
    import eq_pkg::*;

    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned BIT_CLK   = 2 * CLK_DIV;
    localparam int unsigned FRAME_CLK = BIT_CLK * FRAME_BITS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic bclk, lrck, sdata, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] underrun_cnt;
`endif

    i2s_tx_if bus ();

    i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .bclk     (bclk),
        .lrck     (lrck),
        .sdata    (sdata),
        .underrun (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned t = 0;
    sample_t     pending[$];
    sample_t     cur = '0;
    bit          exp_underrun = 1'b0;
    int unsigned exp_cnt = 0;
    bit          started = 1'b0;
    bit          m_rdy;
    int          seen_underruns = 0;
    int unsigned c_f, c_bc, c_k;
    logic        c_sd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic int unsigned cur_bc();
        return (FRAME_BITS - 1 + t / BIT_CLK) % FRAME_BITS;
    endfunction

    // Reference: time since reset decides clocks/slots; a queue models the one-deep buffer.
    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            t = 0;
            pending.delete();
            cur = '0;
            exp_underrun = 1'b0;
            exp_cnt = 0;
        end else begin
            m_rdy = (pending.size() == 0);
            t++;
            exp_underrun = 1'b0;
            if (t % FRAME_CLK == BIT_CLK) begin
                if (!m_rdy) begin
                    cur = pending.pop_front();
                end else begin
                    cur = '0;
                    exp_underrun = 1'b1;
                    if (exp_cnt < 32'hFFFF) exp_cnt++;
                end
            end
            if (bus.sample_valid && m_rdy) pending.push_back(bus.sample_in);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            c_f  = t / BIT_CLK;
            c_bc = (FRAME_BITS - 1 + c_f) % FRAME_BITS;
            c_k  = c_bc % SLOT_W;
            c_sd = 1'b0;
            if (c_k >= 1 && c_k <= SAMPLE_W) c_sd = cur[SAMPLE_W - c_k];
            chk("bclk",     32'(bclk),             32'((t / CLK_DIV) % 2));
            chk("lrck",     32'(lrck),             32'(c_bc >= SLOT_W));
            chk("sdata",    32'(sdata),            32'(c_sd));
            chk("ready",    32'(bus.sample_ready), 32'(pending.size() == 0));
            chk("underrun", 32'(underrun),         32'(exp_underrun));
            if (underrun === 1'b1) seen_underruns++;
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int unsigned n);
        reset = 1'b1;
        wait_cycles(n);
        reset = 1'b0;
    endtask

    task automatic send(input sample_t v);
        int unsigned waited = 0;
        while (bus.sample_ready !== 1'b1 && waited < 2 * FRAME_CLK) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", 32'(bus.sample_ready), 32'd1);
        bus.sample_valid = 1'b1;
        bus.sample_in    = v;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.sample_in    = sample_t'($urandom);
    endtask

    task automatic wait_bc(input int unsigned bc);
        int unsigned waited = 0;
        while (cur_bc() != bc && waited < FRAME_CLK + 4) begin
            @(negedge clk);
            waited++;
        end
        chk("wait_bc", cur_bc(), bc);
    endtask

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned waited;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;

        // Idle after reset: zeros on sdata, one underrun per frame.
        do_reset(3);
        seen_underruns = 0;
        wait_cycles(3 * FRAME_CLK);
        chk("idle_underruns", 32'(seen_underruns), 32'd3);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("idle_underrun_cnt", 32'(underrun_cnt), 32'(exp_cnt));
`endif

        // Single sample ahead of the first frame.
        do_reset(2);
        send(24'h800001);
        chk("ready_after_accept", 32'(bus.sample_ready), 32'd0);
        wait_cycles(2 * FRAME_CLK);

        // Back-to-back feed: no underrun while the source keeps up.
        send(24'h7FFFFF);
        seen_underruns = 0;
        send(24'h000000);
        for (int i = 0; i < 6; i++) send(sample_t'($urandom));
        waited = 0;
        while (bus.sample_ready !== 1'b1 && waited < 2 * FRAME_CLK) begin
            @(negedge clk);
            waited++;
        end
        wait_cycles(2);
        chk("b2b_underruns", 32'(seen_underruns), 32'd0);
        wait_cycles(FRAME_CLK);

        // Valid exactly in the frame-start cycle: that frame underruns, sample goes next.
        waited = 0;
        while (((t + 1) % FRAME_CLK) != BIT_CLK && waited < FRAME_CLK + 4) begin
            @(negedge clk);
            waited++;
        end
        bus.sample_valid = 1'b1;
        bus.sample_in    = sample_t'($urandom);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        chk("fs_underrun", 32'(underrun), 32'd1);
        chk("fs_ready", 32'(bus.sample_ready), 32'd0);
        wait_cycles(2 * FRAME_CLK);

        // Reset at bit 40 with the buffer full: the buffered sample is dropped.
        wait_bc(2);
        send(sample_t'($urandom) | 24'h400000);
        wait_bc(40);
        chk("hold_full_at_40", 32'(bus.sample_ready), 32'd0);
        do_reset(1);
        chk("rst_ready", 32'(bus.sample_ready), 32'd1);
        chk("rst_lrck", 32'(lrck), 32'd1);
        wait_cycles(2 * FRAME_CLK);

        // Random source timing: mix of served frames and underruns.
        for (int i = 0; i < 24; i++) begin
            wait_cycles($urandom_range(0, FRAME_CLK + FRAME_CLK / 2));
            send(sample_t'($urandom));
        end
        wait_cycles(2 * FRAME_CLK);

`ifdef I2S_TX_UNDERRUN_CNT_EN
        // Counter saturation from a preloaded value.
        do_reset(2);
        force dut.underrun_cnt = 16'hFFFE;
        exp_cnt = 32'hFFFE;
        @(negedge clk);
        release dut.underrun_cnt;
        wait_cycles(2 * FRAME_CLK + 8);
        chk("underrun_cnt_sat", 32'(underrun_cnt), 32'h0000FFFF);
        chk("underrun_cnt_model", 32'(underrun_cnt), exp_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
